// File: rtl/ex_mem.sv
// ex_mem: EX->MEM pipeline register.
// It carries the register-write and HI/LO-write results from execute to the
// memory stage. It also holds the multiply-accumulate partial product and
// step count while execute is stalled. This lets a 2-step madd/msub finish.
// Optional feature: define EX_MEM_BUBBLE_CNT_EN to add a 32-bit bubble_cnt
// output. It counts the edges on which a bubble is inserted.
module ex_mem #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic            flush,
  input  logic [4:0]      ex_wd,
  input  logic            ex_wreg,
  input  logic [DW-1:0]   ex_wdata,
  input  logic [DW-1:0]   ex_hi,
  input  logic [DW-1:0]   ex_lo,
  input  logic            ex_whilo,
  input  logic [2*DW-1:0] hilo_i,
  input  logic [1:0]      cnt_i,
  output logic [4:0]      mem_wd,
  output logic            mem_wreg,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW-1:0]   mem_hi,
  output logic [DW-1:0]   mem_lo,
  output logic            mem_whilo,
  output logic [2*DW-1:0] hilo_o,
`ifdef EX_MEM_BUBBLE_CNT_EN
  output logic [1:0]      cnt_o,
  output logic [31:0]     bubble_cnt
`else
  output logic [1:0]      cnt_o
`endif
);

  localparam int unsigned AW  = 5;
  localparam int unsigned HLW = 2 * DW;
  localparam int unsigned CW  = 2;
  localparam int unsigned BCW = 32;

  // Edge action: resolved once so every register agrees on the priority
  typedef enum logic [2:0] {
    ACT_RESET   = 3'd0,
    ACT_FLUSH   = 3'd1,
    ACT_ADVANCE = 3'd2,
    ACT_BUBBLE  = 3'd3,
    ACT_HOLD    = 3'd4
  } act_e;

  act_e w_act;

  logic [AW-1:0]  r_wd;
  logic           r_wreg;
  logic [DW-1:0]  r_wdata;
  logic [DW-1:0]  r_hi;
  logic [DW-1:0]  r_lo;
  logic           r_whilo;
  logic [HLW-1:0] r_hilo;
  logic [CW-1:0]  r_cnt;

  logic w_ex_stall;
  logic w_mem_stall;
  logic w_unused_stall;

  assign w_ex_stall     = stall[3];
  assign w_mem_stall    = stall[4];
  // Only the execute and memory stall bits matter here
  assign w_unused_stall = ^{stall[5], stall[2:0]};

  // Decode edge action: rst > flush > stall cases
  // ex running with mem stalled cannot come from upstream, so it advances
  always_comb begin
    w_act = ACT_ADVANCE;
    if (rst) begin
      w_act = ACT_RESET;
    end else if (flush) begin
      w_act = ACT_FLUSH;
    end else if (!w_ex_stall) begin
      w_act = ACT_ADVANCE;
    end else if (!w_mem_stall) begin
      w_act = ACT_BUBBLE;
    end else begin
      w_act = ACT_HOLD;
    end
  end

  // Forward payload to the memory stage: load, zero (bubble/flush/reset) or keep
  always_ff @(posedge clk) begin
    case (w_act)
      ACT_ADVANCE: begin
        r_wd    <= ex_wd;
        r_wreg  <= ex_wreg;
        r_wdata <= ex_wdata;
        r_hi    <= ex_hi;
        r_lo    <= ex_lo;
        r_whilo <= ex_whilo;
      end
      ACT_HOLD: begin
        r_wd    <= r_wd;
        r_wreg  <= r_wreg;
        r_wdata <= r_wdata;
        r_hi    <= r_hi;
        r_lo    <= r_lo;
        r_whilo <= r_whilo;
      end
      default: begin
        r_wd    <= AW'(0);
        r_wreg  <= 1'b0;
        r_wdata <= DW'(0);
        r_hi    <= DW'(0);
        r_lo    <= DW'(0);
        r_whilo <= 1'b0;
      end
    endcase
  end

  // Madd/msub feedback: kept while execute stalls, cleared otherwise
  always_ff @(posedge clk) begin
    case (w_act)
      ACT_BUBBLE, ACT_HOLD: begin
        r_hilo <= hilo_i;
        r_cnt  <= cnt_i;
      end
      default: begin
        r_hilo <= HLW'(0);
        r_cnt  <= CW'(0);
      end
    endcase
  end

  assign mem_wd    = r_wd;
  assign mem_wreg  = r_wreg;
  assign mem_wdata = r_wdata;
  assign mem_hi    = r_hi;
  assign mem_lo    = r_lo;
  assign mem_whilo = r_whilo;
  assign hilo_o    = r_hilo;
  assign cnt_o     = r_cnt;

`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [BCW-1:0] r_bubble_cnt;

  // Count bubble edges; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (w_act == ACT_RESET) begin
      r_bubble_cnt <= BCW'(0);
    end else if (w_act == ACT_BUBBLE) begin
      r_bubble_cnt <= r_bubble_cnt + BCW'(1);
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
